psum_ctrl: RTL and testbench

- Sequencing controller for the partial-sum buffer, which holds two ping-pong accumulation FIFOs behind a 3-stage adder tree.
- Generates `p_init`, `p_valid_data`, `p_write_zero` and `odd_cnt` for one output layer:
  - zero-fills both FIFOs;
  - accumulates `num_pass` passes per output row;
  - drains each finished row while the next row accumulates;
  - flushes the last row.
- Sits between the conv top-level control and the PE-array/partial-sum-buffer datapath.

---
 rtl/psum_ctrl_pkg.sv | 23 ++
 rtl/psum_ctrl_if.sv | 29 ++
 rtl/psum_beat_cnt.sv | 37 +++
 rtl/psum_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_psum_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/psum_ctrl_pkg.sv
// Shared encodings and defaults for the partial-sum sequencing controller.
package psum_ctrl_pkg;

  localparam int PSUM_ADDR_WIDTH = 8;
  localparam int PSUM_PASS_WIDTH = 8;
  localparam int PSUM_ROW_WIDTH  = 8;
  // Adder-tree latency from FIFO read to FIFO write; shared with the buffer.
  localparam int PSUM_PIPE_LAT   = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ACCUM = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } psum_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_ctrl_if.sv
// PE-array handshake and partial-sum buffer control bundle.
interface psum_ctrl_if;

  logic in_valid;
  logic in_ready;
  logic p_init;
  logic p_valid_data;
  logic p_write_zero;
  logic odd_cnt;

  modport master (
    input  in_valid,
    output in_ready,
    output p_init,
    output p_valid_data,
    output p_write_zero,
    output odd_cnt
  );

  modport slave (
    output in_valid,
    input  in_ready,
    input  p_init,
    input  p_valid_data,
    input  p_write_zero,
    input  odd_cnt
  );

endinterface

// File: rtl/psum_beat_cnt.sv
// Loadable up-counter with a terminal flag; clear takes priority over count.
module psum_beat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic             term
);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  // Next count: clear, advance or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare against last index, so a full-scale length never wraps.
  assign term = (cnt_q == last);

endmodule

// File: rtl/psum_ctrl.sv
// Partial-sum buffer sequencer: zero-fill, multi-pass accumulate with
// overlapped drain of the previous row, final flush.
module psum_ctrl
  import psum_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = PSUM_ADDR_WIDTH,
  parameter int PASS_WIDTH = PSUM_PASS_WIDTH,
  parameter int ROW_WIDTH  = PSUM_ROW_WIDTH,
  parameter int PIPE_LAT   = PSUM_PIPE_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] row_len,
  input  logic [PASS_WIDTH-1:0] num_pass,
  input  logic [ROW_WIDTH-1:0]  num_rows,
  psum_ctrl_if.master           bus,
  output logic                  busy,
  output logic                  done
);

  localparam int                WAIT_W    = cnt_width(PIPE_LAT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PIPE_LAT - 1);

  psum_state_e           state_d, state_q;
  logic [ADDR_WIDTH-1:0] row_len_d, row_len_q;
  logic [PASS_WIDTH-1:0] num_pass_d, num_pass_q;
  logic [ROW_WIDTH-1:0]  num_rows_d, num_rows_q;
  logic [PASS_WIDTH-1:0] pass_d, pass_q;
  logic [ROW_WIDTH-1:0]  row_d, row_q;
  logic                  odd_d, odd_q;
  logic                  p_init_d, p_init_q;
  logic                  drain_d, drain_q;
  logic                  done_d, done_q;
  logic                  busy_d, busy_q;

  logic beat_clr, beat_en, beat_term;
  logic wait_clr, wait_en, wait_term;
  logic in_ready, beat;

  psum_beat_cnt #(.WIDTH(ADDR_WIDTH)) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (beat_clr),
    .en    (beat_en),
    .last  (row_len_q - ADDR_WIDTH'(1)),
    .term  (beat_term)
  );

  psum_beat_cnt #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wait_clr),
    .en    (wait_en),
    .last  (WAIT_LAST),
    .term  (wait_term)
  );

  // Next-state, counter control and next values of registered outputs.
  always_comb begin
    state_d    = state_q;
    row_len_d  = row_len_q;
    num_pass_d = num_pass_q;
    num_rows_d = num_rows_q;
    pass_d     = pass_q;
    row_d      = row_q;
    odd_d      = odd_q;
    beat_clr   = 1'b0;
    beat_en    = 1'b0;
    wait_clr   = 1'b0;
    wait_en    = 1'b0;
    in_ready   = 1'b0;
    beat       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (row_len == '0 || num_pass == '0 || num_rows == '0) begin
            state_d = ST_DONE;
          end else begin
            row_len_d  = row_len;
            num_pass_d = num_pass;
            num_rows_d = num_rows;
            beat_clr   = 1'b1;
            state_d    = ST_INIT;
          end
        end
      end
      ST_INIT: begin
        beat_en = 1'b1;
        if (beat_term) begin
          beat_clr = 1'b1;
          pass_d   = '0;
          row_d    = '0;
          state_d  = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        beat     = bus.in_valid;
        if (beat) begin
          beat_en = 1'b1;
          if (beat_term) begin
            beat_clr = 1'b1;
            wait_clr = 1'b1;
            state_d  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        wait_en = 1'b1;
        if (wait_term) begin
          if (pass_q != num_pass_q - PASS_WIDTH'(1)) begin
            pass_d  = pass_q + PASS_WIDTH'(1);
            state_d = ST_ACCUM;
          end else begin
            odd_d  = ~odd_q;
            pass_d = '0;
            if (row_q != num_rows_q - ROW_WIDTH'(1)) begin
              row_d   = row_q + ROW_WIDTH'(1);
              state_d = ST_ACCUM;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        beat_en = 1'b1;
        if (beat_term) begin
          beat_clr = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes align with the state that owns them; done/busy trail DONE by one cycle.
    p_init_d = (state_d == ST_INIT);
    drain_d  = (state_d == ST_DRAIN);
    done_d   = (state_q == ST_DONE);
    busy_d   = (state_d != ST_IDLE) || (state_q == ST_DONE);
  end

  // State, configuration, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_len_q  <= '0;
      num_pass_q <= '0;
      num_rows_q <= '0;
      pass_q     <= '0;
      row_q      <= '0;
      odd_q      <= 1'b0;
      p_init_q   <= 1'b0;
      drain_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_len_q  <= row_len_d;
      num_pass_q <= num_pass_d;
      num_rows_q <= num_rows_d;
      pass_q     <= pass_d;
      row_q      <= row_d;
      odd_q      <= odd_d;
      p_init_q   <= p_init_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.p_valid_data = beat;
  assign bus.p_write_zero = drain_q | (beat & (pass_q == '0) & (row_q != '0));
  assign bus.p_init       = p_init_q;
  assign bus.odd_cnt      = odd_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_psum_ctrl.sv
// Scoreboard bench for psum_ctrl: directed layers, backpressure, reset, zero config.
module tb_psum_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] row_len = '0;
  logic [7:0] num_pass = '0;
  logic [7:0] num_rows = '0;
  logic       busy, done;

  psum_ctrl_if bus ();
  assign bus.in_valid = in_valid;

  psum_ctrl #(
    .ADDR_WIDTH (8),
    .PASS_WIDTH (8),
    .ROW_WIDTH  (8),
    .PIPE_LAT   (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .row_len  (row_len),
    .num_pass (num_pass),
    .num_rows (num_rows),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected strobe records {p_init, p_valid_data, p_write_zero, odd_cnt, done}
  logic [4:0] exp_q[$];
  logic       exp_odd = 1'b0;

  int   pvd_cnt, pwz_cnt, init_cnt, done_cnt, odd_toggles, busy_cycles, latency;
  logic odd_prev;
  logic [4:0] mon_rec, mon_exp;
  bit   bp_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    pvd_cnt = 0; pwz_cnt = 0; init_cnt = 0; done_cnt = 0;
    odd_toggles = 0; busy_cycles = 0;
    odd_prev = bus.odd_cnt;
  endtask

  task automatic push_layer(input int L, input int P, input int R);
    if (L == 0 || P == 0 || R == 0) begin
      exp_q.push_back({4'b0000, 1'b1} | {3'b000, exp_odd, 1'b0});
      return;
    end
    for (int i = 0; i < L; i++) exp_q.push_back({3'b100, exp_odd, 1'b0});
    for (int r = 0; r < R; r++) begin
      for (int p = 0; p < P; p++)
        for (int i = 0; i < L; i++)
          exp_q.push_back({1'b0, 1'b1, (p == 0 && r > 0), exp_odd, 1'b0});
      exp_odd = ~exp_odd;
    end
    for (int i = 0; i < L; i++) exp_q.push_back({3'b001, exp_odd, 1'b0});
    exp_q.push_back({3'b000, exp_odd, 1'b1});
  endtask

  // Monitor: sample mid-cycle, pop and compare on every strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cycles++;
      if (bus.odd_cnt !== odd_prev) odd_toggles++;
      odd_prev = bus.odd_cnt;
      if (bus.p_valid_data) pvd_cnt++;
      if (bus.p_write_zero) pwz_cnt++;
      if (bus.p_init) init_cnt++;
      if (done) done_cnt++;
      if (bus.p_valid_data) chk("pvd_needs_in_valid", in_valid, 1);
      mon_rec = {bus.p_init, bus.p_valid_data, bus.p_write_zero, bus.odd_cnt, done};
      if (bus.p_init || bus.p_valid_data || bus.p_write_zero || done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe actual=%b expected=none", mon_rec);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_rec !== mon_exp) begin
            errors++;
            $display("FAIL strobe_record actual=%b expected=%b (init,pvd,pwz,odd,done)",
                     mon_rec, mon_exp);
          end
        end
      end
    end
  end

  // mode: 0 plain, 1 extra start pulses during ACCUM, 2 in_valid backpressure pattern
  task automatic run_layer(input int L, input int P, input int R, input int mode);
    int k;
    int pi;
    @(posedge clk); #1;
    clear_stats();
    row_len  = 8'(L);
    num_pass = 8'(P);
    num_rows = 8'(R);
    push_layer(L, P, R);
    in_valid = (mode == 2) ? 1'b0 : 1'b1;
    start    = 1'b1;
    latency  = 0;
    k = 0;
    pi = 0;
    do begin
      @(posedge clk); #1;
      latency++;
      start = 1'b0;
      if (mode == 1 && bus.in_ready && k < 2) begin
        start = 1'b1;
        k++;
      end
      if (mode == 2) begin
        if (bus.in_ready && pi < 7) begin
          in_valid = bp_pat[pi];
          pi++;
        end else if (pi >= 7) begin
          in_valid = 1'b1;
        end
      end
    end while (!done && latency < 2000);
    start = 1'b0;
    chk("done_seen", done, 1);
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #3;
    chk("reset_outputs",
        {bus.in_ready, bus.p_init, bus.p_valid_data, bus.p_write_zero, bus.odd_cnt, busy, done}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Zero config: straight to DONE
    run_layer(4, 0, 1, 0);
    chk("zero_latency", latency, 2);
    chk("zero_busy", busy_cycles, 2);
    chk("zero_init", init_cnt, 0);
    chk("zero_pvd", pvd_cnt, 0);
    chk("zero_pwz", pwz_cnt, 0);
    chk("zero_done", done_cnt, 1);

    // Single row, single pass
    run_layer(4, 1, 1, 0);
    chk("t1_latency", latency, 17);
    chk("t1_busy", busy_cycles, 17);
    chk("t1_init", init_cnt, 4);
    chk("t1_pvd", pvd_cnt, 4);
    chk("t1_pwz", pwz_cnt, 4);
    chk("t1_odd_toggles", odd_toggles, 1);
    chk("t1_done", done_cnt, 1);

    // Multi pass / multi row
    run_layer(5, 3, 2, 0);
    chk("t2_latency", latency, 60);
    chk("t2_pvd", pvd_cnt, 30);
    chk("t2_pwz", pwz_cnt, 10);
    chk("t2_odd_toggles", odd_toggles, 2);
    chk("t2_done", done_cnt, 1);

    // Same layer with start pulses while busy
    run_layer(5, 3, 2, 1);
    chk("t3_latency", latency, 60);
    chk("t3_pvd", pvd_cnt, 30);
    chk("t3_pwz", pwz_cnt, 10);
    chk("t3_odd_toggles", odd_toggles, 2);
    chk("t3_done", done_cnt, 1);

    // Reset during second accumulation pass (odd_cnt is 1 here)
    @(posedge clk); #1;
    clear_stats();
    row_len = 8'd4; num_pass = 8'd2; num_rows = 8'd1;
    push_layer(4, 2, 1);
    in_valid = 1'b1;
    start = 1'b1;
    latency = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      latency++;
    end while (pvd_cnt < 6 && latency < 500);
    chk("rst_reach_pass1", pvd_cnt, 6);
    chk("rst_odd_before", bus.odd_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs",
        {bus.in_ready, bus.p_init, bus.p_valid_data, bus.p_write_zero, bus.odd_cnt, busy, done}, 0);
    chk("rst_pending_records", exp_q.size(), 7);
    exp_q.delete();
    exp_odd = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_no_done", done_cnt, 0);

    // Full sequence again after reset
    run_layer(4, 1, 1, 0);
    chk("t4_latency", latency, 17);
    chk("t4_init", init_cnt, 4);
    chk("t4_pwz", pwz_cnt, 4);
    chk("t4_odd_toggles", odd_toggles, 1);

    // Backpressure 1,0,0,1,1,0,1
    run_layer(4, 1, 1, 2);
    chk("bp_latency", latency, 20);
    chk("bp_pvd", pvd_cnt, 4);
    chk("bp_pwz", pwz_cnt, 4);
    chk("bp_done", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
